// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
// Shared definitions for the nibble-serial adder/subtractor controller and
// anything that needs to reason about it (e.g. its testbench).
//   SLICE_W   : width of one serial slice, in bits
//   state_t   : controller FSM states
//   idx_width : width of the slice index for a given slice count (min 1)
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/four_adder.sv
// -----------------------------------------------------------------------------
// four_adder
// 4-bit ripple add with carry in/out.
// Ports:
//   sum   : out, 4  -- a + b + c_in, low 4 bits
//   c_out : out, 1  -- carry out of bit 3
//   c_in  : in,  1  -- carry in
//   a, b  : in,  4  -- addends
// -----------------------------------------------------------------------------
module four_adder (
  output logic [3:0] sum,
  output logic       c_out,
  input  logic       c_in,
  input  logic [3:0] a,
  input  logic [3:0] b
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Signed add/subtract of two W-bit operands, one 4-bit slice per clock,
// LSB slice first, through a single shared four_adder.
// Parameters:
//   NIBBLES : slices per operand, W = 4*NIBBLES
// Ports:
//   clk    : in,  1  -- clock, rising edge
//   rst_n  : in,  1  -- asynchronous active-low reset
//   start  : in,  1  -- begin an operation (accepted in IDLE or DONE)
//   sub    : in,  1  -- 0: a+b, 1: a-b (sampled with start)
//   a, b   : in,  W  -- signed operands (sampled with start)
//   busy   : out, 1  -- operation in progress
//   done   : out, 1  -- one-cycle result-valid pulse
//   sum    : out, W  -- registered result
//   c_out  : out, 1  -- carry out of MSB slice (sub: 1 = no borrow)
//   ovf    : out, 1  -- signed overflow
// Timing: start accepted at edge N, slices at edges N+1..N+NIBBLES, done high
// in the cycle after edge N+NIBBLES.
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          sub,
  input  logic [SLICE_W*NIBBLES-1:0]    a,
  input  logic [SLICE_W*NIBBLES-1:0]    b,
  output logic                          busy,
  output logic                          done,
  output logic [SLICE_W*NIBBLES-1:0]    sum,
  output logic                          c_out,
  output logic                          ovf
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state_q, state_d;

  // b_q holds B' (already inverted for subtraction); carry_q is preloaded
  // with sub so that the first slice supplies the +1 of two's complement.
  logic signed [W-1:0] a_q;
  logic signed [W-1:0] b_q;
  logic [IDX_W-1:0]    idx_q;
  logic                carry_q;
  logic [W-1:0]        sum_q;
  logic                c_out_q;
  logic                ovf_q;

  logic                accept;
  logic                last_slice;

  logic [SLICE_W-1:0]  a_sl;
  logic [SLICE_W-1:0]  b_sl;
  logic [SLICE_W-1:0]  s_sl;
  logic                c_sl;

  // ---------------------------------------------------------------------------
  // Controller: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller: next state and status outputs
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) begin
          last_slice = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A start here chains straight into the next operation.
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slice select: pick slice idx_q of both latched operands
  // ---------------------------------------------------------------------------
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  four_adder u_slice (
    .sum   (s_sl),
    .c_out (c_sl),
    .c_in  (carry_q),
    .a     (a_sl),
    .b     (b_sl)
  );

  // ---------------------------------------------------------------------------
  // Datapath registers: operand latch, slice write-back, flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      idx_q   <= '0;
      carry_q <= sub;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IDX_W'(i)) begin
          sum_q[i*SLICE_W +: SLICE_W] <= s_sl;
        end
      end
      carry_q <= c_sl;
      if (last_slice) begin
        // Index parks on the last slice rather than wrapping.
        c_out_q <= c_sl;
        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (s_sl[SLICE_W-1] != a_q[W-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (NIBBLES = 4). A time-based model
// of the operation (accept edge, fixed latency, integer add/sub) is checked
// against the DUT every cycle; directed cases pin the model with literals.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W       = SLICE_W * NIBBLES;
  localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W - 1));

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {carry, sum} of a +/- b as plain integers.
  function automatic logic [W:0] ref_full(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint f  = s ? (ux - uy + (longint'(1) <<< W)) : (ux + uy);
    return f[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint t  = s ? (sx - sy) : (sx + sy);
    return (t > MAXS) || (t < MINS);
  endfunction

  // Model: edge_cnt numbers rising edges; an op accepted at edge acc_edge is
  // busy through edge acc_edge+NIBBLES-1 and done after edge acc_edge+NIBBLES.
  int           edge_cnt = 0;
  int           acc_edge = 0;
  bit           pend     = 1'b0;
  logic [W:0]   e_full   = '0;
  logic         e_v      = 1'b0;
  logic [W:0]   h_full   = '0;
  logic         h_v      = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= 1'b0;
      h_full <= '0;
      h_v    <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (pend && edge_cnt == acc_edge + NIBBLES) begin
        h_full <= e_full;
        h_v    <= e_v;
      end
      if (start && !(pend && edge_cnt > acc_edge && edge_cnt <= acc_edge + NIBBLES)) begin
        pend     <= 1'b1;
        acc_edge <= edge_cnt;
        e_full   <= ref_full(a, b, sub);
        e_v      <= ref_ovf(a, b, sub);
      end
    end
  end

  logic exp_busy;
  logic exp_done;
  assign exp_busy = pend && (edge_cnt - 1 >= acc_edge) && (edge_cnt - 1 <= acc_edge + NIBBLES - 1);
  assign exp_done = pend && (edge_cnt - 1 == acc_edge + NIBBLES);

  // Per-cycle compare; result outputs are only meaningful when not busy.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    if (!exp_busy) begin
      chk("sum",   32'(sum),   32'(h_full[W-1:0]));
      chk("c_out", 32'(c_out), 32'(h_full[W]));
      chk("ovf",   32'(ovf),   32'(h_v));
    end
  end

  task automatic run_op(input string nm, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic s, input logic [W-1:0] xs, input logic xc, input logic xv);
    int n;
    @(negedge clk);
    a = xa; b = xb; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd4);
    chk({nm, "_sum"},     32'(sum),   32'(xs));
    chk({nm, "_c_out"},   32'(c_out), 32'(xc));
    chk({nm, "_ovf"},     32'(ovf),   32'(xv));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = {1'b0, {(W-1){1'b1}}};
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = '1;
      4: v = W'(1);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int n;
    int m;
    int seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sum",   32'(sum),   32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed literal cases
    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start during RUN is ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("ignore_done_count", 32'(seen), 32'd1);
    chk("ignore_sum",        32'(sum),  32'h5555);

    // start held through DONE: back-to-back
    @(negedge clk);
    a = 16'h0005; b = 16'h0007; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001; sub = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_sum", 32'(sum), 32'hFFFE);
    chk("b2b_first_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap_busy", 32'(busy), 32'd1);
    m = 1;
    while (done !== 1'b1 && m < 20) begin
      @(negedge clk);
      m++;
    end
    chk("b2b_spacing",    32'(m),   32'd5);
    chk("b2b_second_sum", 32'(sum), 32'h8000);
    chk("b2b_second_ovf", 32'(ovf), 32'd1);

    // Reset in the second RUN cycle
    @(negedge clk);
    a = 16'h7FFF; b = 16'h7FFF; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_done",  32'(done),  32'd0);
    chk("abort_sum",   32'(sum),   32'd0);
    chk("abort_c_out", 32'(c_out), 32'd0);
    chk("abort_ovf",   32'(ovf),   32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op("after_abort", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      a     = pick();
      b     = pick();
      sub   = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; data width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation; sampled on clk.
REQ-005 SHALL have port sub, input, 1, operation select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port a, input, W, signed operand A; sampled with start.
REQ-007 SHALL have port b, input, W, signed operand B; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking that the result is valid.
REQ-010 SHALL have port sum, output, W, registered result.
REQ-011 SHALL have port c_out, output, 1, carry out of the MSB slice (for sub: 1 = no borrow).
REQ-012 SHALL have port ovf, output, 1, signed two's-complement overflow flag.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL latch a, b (b inverted when sub=1) and sub, clear the slice index to 0, preload carry = sub, and enter RUN.
REQ-015 start SHALL be ignored while in RUN; latched operands SHALL NOT change.
REQ-016 Each RUN cycle SHALL add one 4-bit slice, LSB first: slice i of A, slice i of B', carry-in = stored carry. It SHALL write the 4-bit result into sum[4i+3:4i] and store the slice carry-out.
REQ-017 After slice NIBBLES-1, the FSM SHALL enter DONE; c_out SHALL equal the final slice carry; ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]).
REQ-018 Latency SHALL be fixed: start accepted at edge N, slices processed at edges N+1..N+NIBBLES, done=1 for exactly the cycle following edge N+NIBBLES.
REQ-019 DONE SHALL last one cycle; the FSM SHALL then go to IDLE, or to RUN when start=1 (back-to-back operation with no idle gap).
REQ-020 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-021 sum, c_out and ovf SHALL hold their values from DONE until the next accepted start; intermediate slices MAY be visible on sum while busy=1.
REQ-022 The slice index SHALL be ceil(log2(NIBBLES)) bits wide (minimum 1) and SHALL NOT wrap past NIBBLES-1.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, index=0, carry=0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as from power-up.

Structure
REQ-025 FSM state encodings and the slice width constant (4) SHALL live in a shared package/include used by the controller and the bench.
REQ-026 The 4-bit slice add SHALL be one instance of the existing four_adder (port order sum, c_out, c_in, a, b); no other sub-modules.

Verification
REQ-027 NIBBLES=4, a=0x1234, b=0x4321, sub=0 -> sum=0x5555, c_out=0, ovf=0; done pulses exactly 4 cycles after start is accepted.
REQ-028 a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, c_out=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
REQ-029 a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-030 start pulsed again with new operands during RUN -> ignored; result matches the first operands; exactly one done pulse.
REQ-031 start held high in DONE -> second operation begins with no idle cycle; two done pulses 5 cycles apart.
REQ-032 rst_n dropped at the second RUN cycle -> all outputs are 0 immediately and no done pulse; the next operation returns the correct result.
